// File: rtl/qspi_mem_ctrl.sv
// qspi_mem_ctrl: Quad-SPI master that turns 1-4 byte CPU requests into flash/RAM bus transactions.
// Latency: done pulses in cycle 1+2T after accept (T = nibble count); a rejected flash write answers in cycle 1.
// Backpressure: start is taken only while busy=0; starts during busy are dropped, so callers wait on busy.

module qspi_mem_ctrl #(
  parameter int FLASH_DUMMY = 4,
  parameter int RAM_DUMMY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [24:0] addr,
  input  logic        write,
  input  logic [1:0]  len,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [3:0]  qspi_data_out,
  output logic [3:0]  qspi_data_oe,
  input  logic [3:0]  qspi_data_in,
  output logic        qspi_clk,
  output logic        qspi_flash_select,
  output logic        qspi_ram_a_select,
  output logic        qspi_ram_b_select
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_END, S_ERR
  } state_t;

  localparam logic [7:0] FD_LAST = 8'(FLASH_DUMMY - 1);
  localparam logic [7:0] RD_LAST = 8'(RAM_DUMMY - 1);
  // A zero dummy count jumps straight to the data phase.
  localparam state_t FLASH_AFTER_MODE = (FLASH_DUMMY > 0) ? S_DUMMY : S_DATA;
  localparam state_t RAM_AFTER_ADDR   = (RAM_DUMMY > 0) ? S_DUMMY : S_DATA;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;   // 0: qspi_clk low half, 1: high half of a nibble
  logic [7:0]  nib_q, nib_d;       // nibble index inside the current state
  logic [24:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [1:0]  len_q, len_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rx_q, rx_d;         // read bytes being assembled
  logic [31:0] rdata_q, rdata_d;   // last completed read, held between reads
  logic        err_q, err_d;

  logic        active;
  logic        oe_on;
  logic [3:0]  tx_nib;
  logic [7:0]  last_nib;
  state_t      next_state;
  logic [7:0]  cmd_byte;
  logic [23:0] addr_sh;
  logic [4:0]  nib_bit;            // bit offset of the current data nibble, high nibble first

  assign active   = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_MODE) ||
                    (state_q == S_DUMMY) || (state_q == S_DATA);
  assign cmd_byte = write_q ? 8'h02 : 8'h0B;
  assign addr_sh  = addr_q[23:0] << {nib_q[2:0], 2'b00};
  assign nib_bit  = {nib_q[2:1], ~nib_q[0], 2'b00};

  // State and request registers; reset drops every select at once through the state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      nib_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      len_q   <= '0;
      wdata_q <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      nib_q   <= nib_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Length of each phase and the phase that follows it.
  always_comb begin
    last_nib   = 8'd0;
    next_state = S_IDLE;
    case (state_q)
      S_CMD: begin
        last_nib   = 8'd1;
        next_state = S_ADDR;
      end
      S_ADDR: begin
        last_nib = 8'd5;
        if (!addr_q[24])  next_state = S_MODE;
        else if (write_q) next_state = S_DATA;
        else              next_state = RAM_AFTER_ADDR;
      end
      S_MODE: begin
        last_nib   = 8'd1;
        next_state = FLASH_AFTER_MODE;
      end
      S_DUMMY: begin
        last_nib   = addr_q[24] ? RD_LAST : FD_LAST;
        next_state = S_DATA;
      end
      S_DATA: begin
        last_nib   = {5'd0, len_q, 1'b1};
        next_state = S_END;
      end
      default: ;
    endcase
  end

  // Request acceptance, nibble sequencing and read-data capture.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    nib_d   = nib_q;
    addr_d  = addr_q;
    write_d = write_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_END, S_ERR: begin
        state_d = S_IDLE;
        if (start) begin
          addr_d  = addr;
          write_d = write;
          len_d   = len;
          wdata_d = wdata;
          err_d   = 1'b0;
          rx_d    = '0;
          phase_d = 1'b0;
          nib_d   = '0;
          if (!addr[24] && write) begin
            // Flash is read-only: answer at once without touching the bus.
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (addr[24]) begin
            state_d = S_CMD;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      default: begin
        phase_d = ~phase_q;
        // The device drives its nibble during the low half; take it at the rising qspi_clk edge.
        if (state_q == S_DATA && !write_q && !phase_q) begin
          rx_d[nib_bit +: 4] = qspi_data_in;
        end
        if (phase_q) begin
          if (nib_q == last_nib) begin
            nib_d   = '0;
            state_d = next_state;
            if (state_q == S_DATA && !write_q) begin
              rdata_d = rx_q;
            end
          end else begin
            nib_d = nib_q + 8'd1;
          end
        end
      end
    endcase
  end

  // Nibble presented on the bus for the current phase.
  always_comb begin
    tx_nib = 4'h0;
    oe_on  = 1'b0;
    case (state_q)
      S_CMD: begin
        oe_on  = 1'b1;
        tx_nib = nib_q[0] ? cmd_byte[3:0] : cmd_byte[7:4];
      end
      S_ADDR: begin
        oe_on  = 1'b1;
        tx_nib = addr_sh[23:20];
      end
      S_MODE: begin
        oe_on  = 1'b1;
        tx_nib = nib_q[0] ? 4'h0 : 4'hA;
      end
      S_DATA: begin
        oe_on  = write_q;
        tx_nib = write_q ? wdata_q[nib_bit +: 4] : 4'h0;
      end
      default: ;
    endcase
  end

  assign busy              = active;
  assign done              = (state_q == S_END) || (state_q == S_ERR);
  assign err               = err_q;
  assign rdata             = rdata_q;
  assign qspi_clk          = active && phase_q;
  assign qspi_data_out     = oe_on ? tx_nib : 4'h0;
  assign qspi_data_oe      = {4{oe_on}};
  assign qspi_flash_select = !(active && !addr_q[24]);
  assign qspi_ram_a_select = !(active && addr_q[24] && !addr_q[23]);
  assign qspi_ram_b_select = !(active && addr_q[24] && addr_q[23]);

endmodule
